// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter: shares one SDRAM Avalon read master between audio (high priority) and chart fetchers,
// with anti-starvation streak limiting and a read-data timeout.
module sdram_read_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        aud_req,
  input  logic [31:0] aud_addr,
  output logic [31:0] aud_data,
  output logic        aud_rdv,
  input  logic        chart_req,
  input  logic [31:0] chart_addr,
  output logic [31:0] chart_data,
  output logic        chart_rdv,
  output logic        tl_read,
  output logic [31:0] tl_addr,
  input  logic        tl_waitreq,
  input  logic        tl_rdv,
  input  logic [31:0] sample,
  output logic        busy,
  output logic        timeout_err
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(STREAK_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
  state_t r_state, w_next;
  logic r_owner, r_hit;
  logic [31:0] r_addr;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_cnt;
  logic w_aud_elig, w_chart_elig, w_grant, w_pick_chart, w_done;
  always_comb begin
    w_aud_elig = aud_req & ~aud_rdv;
    w_chart_elig = chart_req & ~chart_rdv;
    w_grant = r_state == IDLE && (w_aud_elig || w_chart_elig);
    w_pick_chart = w_chart_elig && (!w_aud_elig || r_streak == SW'(STREAK_MAX));
    w_done = r_state == WAIT_DATA && (tl_rdv || r_hit);
    w_next = r_state == IDLE ? (w_grant ? ISSUE : IDLE) :
             r_state == ISSUE ? (tl_waitreq ? ISSUE : WAIT_DATA) :
             (w_done ? IDLE : WAIT_DATA);
    tl_read = r_state == ISSUE;
    tl_addr = tl_read ? r_addr : 32'h0;
    busy = r_state != IDLE;
  end
  // r_hit trails the counter by one cycle so the abandoned read completes TIMEOUT+1 cycles after WAIT_DATA entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_hit <= 1'b0;
      r_addr <= 32'h0;
      r_streak <= '0;
      r_cnt <= '0;
      aud_data <= 32'h0;
      aud_rdv <= 1'b0;
      chart_data <= 32'h0;
      chart_rdv <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      aud_rdv <= 1'b0;
      chart_rdv <= 1'b0;
      if (w_grant) begin
        r_owner <= w_pick_chart;
        r_addr <= w_pick_chart ? chart_addr : aud_addr;
        r_streak <= (w_pick_chart || !chart_req) ? '0 :
                    r_streak == SW'(STREAK_MAX) ? r_streak : r_streak + SW'(1);
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
        r_hit <= 1'b0;
      end
      if (r_state == WAIT_DATA) begin
        r_cnt <= r_cnt + TW'(1);
        r_hit <= r_cnt == TW'(TIMEOUT - 1);
      end
      if (w_done) begin
        if (r_owner) begin
          chart_data <= tl_rdv ? sample : 32'h0;
          chart_rdv <= 1'b1;
        end else begin
          aud_data <= tl_rdv ? sample : 32'h0;
          aud_rdv <= 1'b1;
        end
        if (!tl_rdv) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb_sdram_read_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sdram_read_arbiter;
  localparam int SMAX = 4;
  localparam int TMO = 16;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic aud_req = 1'b0;
  logic [31:0] aud_addr = 32'h0;
  logic [31:0] aud_data;
  logic aud_rdv;
  logic chart_req = 1'b0;
  logic [31:0] chart_addr = 32'h0;
  logic [31:0] chart_data;
  logic chart_rdv;
  logic tl_read;
  logic [31:0] tl_addr;
  logic tl_waitreq = 1'b0;
  logic tl_rdv = 1'b0;
  logic [31:0] sample = 32'h0;
  logic busy;
  logic timeout_err;
  int checks = 0;
  int failures = 0;

  sdram_read_arbiter #(.STREAK_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_data(aud_data), .aud_rdv(aud_rdv),
    .chart_req(chart_req), .chart_addr(chart_addr), .chart_data(chart_data), .chart_rdv(chart_rdv),
    .tl_read(tl_read), .tl_addr(tl_addr), .tl_waitreq(tl_waitreq), .tl_rdv(tl_rdv), .sample(sample),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    aud_req = 1'b0;
    chart_req = 1'b0;
    aud_addr = 32'h0;
    chart_addr = 32'h0;
    tl_waitreq = 1'b0;
    tl_rdv = 1'b0;
    sample = 32'h0;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  // Requests one read; rdv_after = WAIT_DATA cycles before tl_rdv (-1 = never). lat counts from the request cycle.
  task automatic run_read(input bit who, input logic [31:0] addr, input int rdv_after,
                          input logic [31:0] smp, output int lat, output logic [31:0] got);
    int c;
    c = -1;
    lat = -1;
    got = 'x;
    if (who) begin chart_req = 1'b1; chart_addr = addr; end
    else begin aud_req = 1'b1; aud_addr = addr; end
    tl_waitreq = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick;
      if (who ? chart_rdv : aud_rdv) begin
        lat = i;
        got = who ? chart_data : aud_data;
        break;
      end
      c = (busy && !tl_read) ? c + 1 : -1;
      tl_rdv = (c >= 0) && (c == rdv_after);
      sample = smp;
    end
    aud_req = 1'b0;
    chart_req = 1'b0;
    tl_rdv = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if ({busy, tl_read, aud_rdv, chart_rdv, timeout_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {busy, tl_read, aud_rdv, chart_rdv, timeout_err}); end
    checks++; if (tl_addr !== 32'h0) begin failures++; $display("FAIL reset_tl_addr got=%h exp=0", tl_addr); end
    checks++; if (aud_data !== 32'h0) begin failures++; $display("FAIL reset_aud_data got=%h exp=0", aud_data); end
    checks++; if (chart_data !== 32'h0) begin failures++; $display("FAIL reset_chart_data got=%h exp=0", chart_data); end
  endtask

  task automatic test_audio_single;
    do_reset;
    aud_req = 1'b1;
    aud_addr = 32'h10;
    tick;
    checks++; if ({tl_read, tl_addr} !== {1'b1, 32'h10}) begin failures++; $display("FAIL single_issue got=%b/%h exp=1/00000010", tl_read, tl_addr); end
    tick;
    checks++; if ({busy, tl_read, tl_addr} !== {1'b1, 1'b0, 32'h0}) begin failures++; $display("FAIL single_wait got=%b/%b/%h exp=1/0/0", busy, tl_read, tl_addr); end
    tick;
    tl_rdv = 1'b1;
    sample = 32'hCAFEBABE;
    tick;
    tl_rdv = 1'b0;
    sample = 32'h0;
    checks++; if ({aud_rdv, aud_data} !== {1'b1, 32'hCAFEBABE}) begin failures++; $display("FAIL single_rdv got=%b/%h exp=1/cafebabe", aud_rdv, aud_data); end
    checks++; if ({chart_rdv, busy} !== 2'b00) begin failures++; $display("FAIL single_other got=%b exp=00", {chart_rdv, busy}); end
    aud_req = 1'b0;
    tick;
    checks++; if ({aud_rdv, aud_data} !== {1'b0, 32'hCAFEBABE}) begin failures++; $display("FAIL single_hold got=%b/%h exp=0/cafebabe", aud_rdv, aud_data); end
  endtask

  task automatic test_streak;
    int ng;
    bit prev_read;
    bit order[10];
    logic [31:0] an, cn;
    do_reset;
    ng = 0;
    prev_read = 1'b0;
    an = 32'h1000;
    cn = 32'h2000;
    aud_req = 1'b1;
    chart_req = 1'b1;
    aud_addr = an;
    chart_addr = cn;
    for (int i = 0; i < 400 && ng < 10; i++) begin
      tick;
      if (tl_read && !prev_read) begin order[ng] = tl_addr[13]; ng++; end
      prev_read = tl_read;
      tl_rdv = busy && !tl_read;
      if (aud_rdv || chart_rdv) begin
        aud_req = 1'b0;
        chart_req = 1'b0;
      end else begin
        if (!aud_req) begin an = an + 1; aud_addr = an; end
        if (!chart_req) begin cn = cn + 1; chart_addr = cn; end
        aud_req = 1'b1;
        chart_req = 1'b1;
      end
    end
    tl_rdv = 1'b0;
    aud_req = 1'b0;
    chart_req = 1'b0;
    checks++; if (ng != 10) begin failures++; $display("FAIL streak_grants got=%0d exp=10", ng); end
    for (int i = 0; i < ng; i++) begin
      checks++; if (order[i] !== 1'(i % 5 == 4)) begin failures++; $display("FAIL streak_order[%0d] got_chart=%b exp_chart=%b", i, order[i], i % 5 == 4); end
    end
  endtask

  task automatic test_waitreq;
    int acc, held;
    do_reset;
    acc = 0;
    held = 0;
    chart_req = 1'b1;
    chart_addr = 32'h55AA0000;
    tl_waitreq = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick;
      if (tl_read && tl_addr === 32'h55AA0000) held++;
      tl_waitreq = i < 6;
      if (tl_read && !tl_waitreq) acc++;
    end
    tl_rdv = 1'b1;
    sample = 32'h13572468;
    tick;
    tl_rdv = 1'b0;
    chart_req = 1'b0;
    checks++; if (held != 6) begin failures++; $display("FAIL waitreq_held got=%0d exp=6", held); end
    checks++; if (acc != 1) begin failures++; $display("FAIL waitreq_accepts got=%0d exp=1", acc); end
    checks++; if ({chart_rdv, aud_rdv, chart_data} !== {2'b10, 32'h13572468}) begin failures++; $display("FAIL waitreq_data got=%b%b/%h exp=10/13572468", chart_rdv, aud_rdv, chart_data); end
  endtask

  task automatic test_timeout;
    int lat;
    logic [31:0] d;
    do_reset;
    run_read(1'b0, 32'h40, 0, 32'hDEADBEEF, lat, d);
    checks++; if (lat != 3 || d !== 32'hDEADBEEF) begin failures++; $display("FAIL min_latency got=%0d/%h exp=3/deadbeef", lat, d); end
    run_read(1'b0, 32'h44, -1, 32'h12345678, lat, d);
    checks++; if (lat != TMO + 3 || d !== 32'h0) begin failures++; $display("FAIL timeout_rdv got=%0d/%h exp=%0d/0", lat, d, TMO + 3); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_set got=%b exp=1", timeout_err); end
    run_read(1'b1, 32'h48, 1, 32'h0BADF00D, lat, d);
    checks++; if (lat != 4 || d !== 32'h0BADF00D) begin failures++; $display("FAIL after_timeout_read got=%0d/%h exp=4/0badf00d", lat, d); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_sticky got=%b exp=1", timeout_err); end
    do_reset;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_err_reset got=%b exp=0", timeout_err); end
  endtask

  task automatic test_coincide;
    int lat;
    logic [31:0] d;
    do_reset;
    run_read(1'b0, 32'h80, TMO, 32'hA5A5A5A5, lat, d);
    checks++; if (lat != TMO + 3 || d !== 32'hA5A5A5A5) begin failures++; $display("FAIL coincide_data got=%0d/%h exp=%0d/a5a5a5a5", lat, d, TMO + 3); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL coincide_err got=%b exp=0", timeout_err); end
    run_read(1'b1, 32'h84, TMO - 1, 32'h5A5A5A5A, lat, d);
    checks++; if (lat != TMO + 2 || d !== 32'h5A5A5A5A) begin failures++; $display("FAIL near_timeout got=%0d/%h exp=%0d/5a5a5a5a", lat, d, TMO + 2); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [31:0] d;
    do_reset;
    run_read(1'b0, 32'h90, 0, 32'h11112222, lat, d);
    aud_req = 1'b1;
    aud_addr = 32'h99;
    for (int i = 0; i < 4; i++) tick;
    checks++; if ({busy, tl_read} !== 2'b10) begin failures++; $display("FAIL reset_mid_pre got=%b exp=10", {busy, tl_read}); end
    Reset = 1'b1;
    aud_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      Reset = 1'b0;
      tl_rdv = i == 0;
      sample = 32'hFFFF0000;
      checks++; if ({busy, tl_read, aud_rdv, chart_rdv, timeout_err, tl_addr, aud_data} !== 69'h0) begin failures++; $display("FAIL reset_mid[%0d] flags=%b tl_addr=%h aud_data=%h exp=0", i, {busy, tl_read, aud_rdv, chart_rdv, timeout_err}, tl_addr, aud_data); end
    end
    tl_rdv = 1'b0;
  endtask

  task automatic test_random;
    bit m_act, m_acc, m_own, m_err, e_ard, e_crd, n_ard, n_crd, ae, ce, pick, a_new, c_new, e_read;
    int m_streak, m_wstart;
    logic [31:0] m_addr, e_ad, e_cd;
    do_reset;
    m_act = 0; m_acc = 0; m_own = 0; m_err = 0; e_ard = 0; e_crd = 0; a_new = 0; c_new = 0;
    m_streak = 0; m_wstart = 0; m_addr = 0; e_ad = 0; e_cd = 0;
    for (int cyc = 0; cyc < 3000 && failures < 40; cyc++) begin
      e_read = m_act && !m_acc;
      checks++; if ({busy, tl_read} !== {m_act, e_read}) begin failures++; $display("FAIL rnd_state@%0d got=%b%b exp=%b%b", cyc, busy, tl_read, m_act, e_read); end
      checks++; if (tl_addr !== (e_read ? m_addr : 32'h0)) begin failures++; $display("FAIL rnd_tl_addr@%0d got=%h exp=%h", cyc, tl_addr, e_read ? m_addr : 32'h0); end
      checks++; if ({aud_rdv, aud_data} !== {e_ard, e_ad}) begin failures++; $display("FAIL rnd_aud@%0d got=%b/%h exp=%b/%h", cyc, aud_rdv, aud_data, e_ard, e_ad); end
      checks++; if ({chart_rdv, chart_data} !== {e_crd, e_cd}) begin failures++; $display("FAIL rnd_chart@%0d got=%b/%h exp=%b/%h", cyc, chart_rdv, chart_data, e_crd, e_cd); end
      checks++; if (timeout_err !== m_err) begin failures++; $display("FAIL rnd_timeout_err@%0d got=%b exp=%b", cyc, timeout_err, m_err); end
      if (aud_req) begin
        if (a_new) begin aud_addr = $urandom; a_new = 0; end
        if (aud_rdv) begin if ($urandom_range(0, 1) == 1) a_new = 1; else aud_req = 1'b0; end
      end else if ($urandom_range(0, 2) == 0) begin aud_req = 1'b1; aud_addr = $urandom; end
      if (chart_req) begin
        if (c_new) begin chart_addr = $urandom; c_new = 0; end
        if (chart_rdv) begin if ($urandom_range(0, 1) == 1) c_new = 1; else chart_req = 1'b0; end
      end else if ($urandom_range(0, 2) == 0) begin chart_req = 1'b1; chart_addr = $urandom; end
      tl_waitreq = $urandom_range(0, 2) == 0;
      tl_rdv = $urandom_range(0, 9) == 0;
      sample = $urandom;
      n_ard = 0;
      n_crd = 0;
      if (!m_act) begin
        ae = aud_req && !e_ard;
        ce = chart_req && !e_crd;
        if (ae || ce) begin
          pick = ce && (!ae || m_streak == SMAX);
          m_streak = (pick || !chart_req) ? 0 : (m_streak < SMAX ? m_streak + 1 : SMAX);
          m_act = 1; m_acc = 0; m_own = pick;
          m_addr = pick ? chart_addr : aud_addr;
        end
      end else if (!m_acc) begin
        if (!tl_waitreq) begin m_acc = 1; m_wstart = cyc + 1; end
      end else if (tl_rdv || cyc - m_wstart == TMO) begin
        if (m_own) begin e_cd = tl_rdv ? sample : 32'h0; n_crd = 1; end
        else begin e_ad = tl_rdv ? sample : 32'h0; n_ard = 1; end
        if (!tl_rdv) m_err = 1;
        m_act = 0;
      end
      e_ard = n_ard;
      e_crd = n_crd;
      tick;
    end
    aud_req = 1'b0;
    chart_req = 1'b0;
    tl_rdv = 1'b0;
  endtask

  initial begin
    test_reset;
    test_audio_single;
    test_streak;
    test_waitreq;
    test_timeout;
    test_coincide;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
